// File: rtl/mem_banked.sv
// Banked single-port word RAM: LANES columns by NBANKS rows of banks, registered read with
// valid pulse, per-lane write enables and a zeroing init walk after reset or clr.
module mem_banked #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LANE_W      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned BANK_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       r_w,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          d_in,
  input  logic [DATA_W/LANE_W-1:0]   lane_we,
  output logic [DATA_W-1:0]          d_out,
  output logic                       rd_valid,
  output logic                       ready,
  output logic                       busy
);

  localparam int unsigned LANES  = DATA_W / LANE_W;
  localparam int unsigned NBANKS = 1 << (ADDR_W - BANK_ADDR_W);
  localparam int unsigned ROWS   = 1 << BANK_ADDR_W;
  localparam int unsigned BSEL_W = (ADDR_W > BANK_ADDR_W) ? (ADDR_W - BANK_ADDR_W) : 1;

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  logic                   state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [BSEL_W-1:0]      bank_q, bank_d;

  logic                   run;
  logic                   rd_req;
  logic                   wr_req;
  logic                   init_we;
  logic [ADDR_W-1:0]      acc_addr;
  logic [BSEL_W-1:0]      acc_bank;
  logic [BANK_ADDR_W-1:0] acc_row;
  logic [LANE_W-1:0]      lane_rd [NBANKS*LANES];

  assign run      = (state_q == StRun);
  assign rd_req   = run & en & ~r_w & ~clr;
  assign wr_req   = run & en & r_w & ~clr;
  assign init_we  = ~run & ~clr;
  // The init walk borrows the access port, driving the counter as the address.
  assign acc_addr = run ? addr : cnt_q;
  assign acc_row  = acc_addr[BANK_ADDR_W-1:0];

  if (ADDR_W > BANK_ADDR_W) begin : g_multi_bank
    assign acc_bank = acc_addr[ADDR_W-1:BANK_ADDR_W];
  end else begin : g_single_bank
    assign acc_bank = '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    rd_valid_d = rd_req;
    if (clr) begin
      state_d = StInit;
      cnt_d   = '0;
    end else if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = StRun;
      end
    end
    if (rd_req) begin
      bank_d = acc_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      bank_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      bank_q     <= bank_d;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic hit;
    assign hit = (acc_bank == BSEL_W'(b));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [LANE_W-1:0] mem [ROWS];
      logic [LANE_W-1:0] rd_q;
      logic              we;
      logic [LANE_W-1:0] wdata;

      assign we    = hit & (init_we | (wr_req & lane_we[l]));
      assign wdata = init_we ? '0 : d_in[l*LANE_W +: LANE_W];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[acc_row] <= wdata;
        end
      end

      // Per-bank output register only loads on a read to this bank, so d_out holds when idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
        end else if (hit && rd_req) begin
          rd_q <= mem[acc_row];
        end
      end

      assign lane_rd[b*LANES+l] = rd_q;
    end
  end

  always_comb begin
    d_out = '0;
    for (int l = 0; l < LANES; l++) begin
      d_out[l*LANE_W +: LANE_W] = lane_rd[int'(bank_q)*LANES + l];
    end
  end

  assign rd_valid = rd_valid_q;
  assign ready    = run;
  assign busy     = ~run;

endmodule

// File: tb/tb_mem_banked.sv
// Directed bench for mem_banked: init walk timing, vector table for RUN accesses,
// and hand sequences for clr and asynchronous reset during the walk.
module tb_mem_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        en;
  logic        r_w;
  logic [5:0]  addr;
  logic [31:0] d_in;
  logic [1:0]  lane_we;
  logic [31:0] d_out;
  logic        rd_valid;
  logic        ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        en;
    logic        r_w;
    logic [5:0]  addr;
    logic [31:0] d;
    logic [1:0]  we;
    logic        valid;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [17];

  mem_banked #(
    .DATA_W      (32),
    .LANE_W      (16),
    .ADDR_W      (6),
    .BANK_ADDR_W (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .r_w      (r_w),
    .addr     (addr),
    .d_in     (d_in),
    .lane_we  (lane_we),
    .d_out    (d_out),
    .rd_valid (rd_valid),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Count edges until ready rises (bounded), flagging any rd_valid or busy/ready disagreement.
  task automatic wait_ready(input string name, input int exp_cycles);
    int c   = 0;
    int bad = 0;
    while (!ready && c < 300) begin
      @(posedge clk);
      #1;
      c++;
      if (rd_valid !== 1'b0) bad++;
      if (busy === ready) bad++;
    end
    check({name, " cycles"}, 32'(c), 32'(exp_cycles));
    check({name, " stray valid/busy"}, 32'(bad), 32'd0);
  endtask

  task automatic cyc(input logic e, input logic w, input logic [5:0] a, input logic [31:0] d,
                     input logic [1:0] we);
    en      = e;
    r_w     = w;
    addr    = a;
    d_in    = d;
    lane_we = we;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 6'd5,  32'hDEADBEEF, 2'b11, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 2'b00, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 6'd5,  32'h12345678, 2'b01, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 2'b00, 1'b1, 32'hDEAD5678};
    vecs[4]  = '{1'b1, 1'b1, 6'd5,  32'hAAAA0000, 2'b10, 1'b0, 32'hDEAD5678};
    vecs[5]  = '{1'b1, 1'b0, 6'd5,  32'h00000000, 2'b00, 1'b1, 32'hAAAA5678};
    vecs[6]  = '{1'b1, 1'b1, 6'd31, 32'h11111111, 2'b11, 1'b0, 32'hAAAA5678};
    vecs[7]  = '{1'b1, 1'b1, 6'd32, 32'h22222222, 2'b11, 1'b0, 32'hAAAA5678};
    vecs[8]  = '{1'b1, 1'b0, 6'd32, 32'h00000000, 2'b00, 1'b1, 32'h22222222};
    vecs[9]  = '{1'b1, 1'b0, 6'd31, 32'h00000000, 2'b00, 1'b1, 32'h11111111};
    vecs[10] = '{1'b1, 1'b0, 6'd0,  32'h00000000, 2'b00, 1'b1, 32'h00000000};
    vecs[11] = '{1'b0, 1'b0, 6'd31, 32'h00000000, 2'b00, 1'b0, 32'h00000000};
    vecs[12] = '{1'b1, 1'b1, 6'd40, 32'h0BADF00D, 2'b11, 1'b0, 32'h00000000};
    vecs[13] = '{1'b1, 1'b1, 6'd40, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h00000000};
    vecs[14] = '{1'b1, 1'b0, 6'd40, 32'h00000000, 2'b00, 1'b1, 32'h0BADF00D};
    vecs[15] = '{1'b1, 1'b0, 6'd63, 32'h00000000, 2'b00, 1'b1, 32'h00000000};
    vecs[16] = '{1'b0, 1'b1, 6'd63, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h00000000};

    rst = 1'b1; clr = 1'b0; en = 1'b0; r_w = 1'b0; addr = '0; d_in = '0; lane_we = '0;
    #12;
    check("reset d_out", d_out, 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd1);

    en = 1'b1; r_w = 1'b0; addr = 6'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready("init walk", 64);

    for (int a = 0; a < 64; a++) begin
      cyc(1'b1, 1'b0, 6'(a), 32'h0, 2'b00);
      check($sformatf("init read %0d valid", a), 32'(rd_valid), 32'd1);
      check($sformatf("init read %0d data", a), d_out, 32'h0);
    end

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].en, vecs[i].r_w, vecs[i].addr, vecs[i].d, vecs[i].we);
      check($sformatf("vec %0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].valid));
      check($sformatf("vec %0d d_out", i), d_out, vecs[i].dout);
    end

    // clr together with a write: write must be dropped and the array re-zeroed.
    clr = 1'b1;
    cyc(1'b1, 1'b1, 6'd7, 32'h5555AAAA, 2'b11);
    clr = 1'b0;
    en  = 1'b0;
    check("clr ready", 32'(ready), 32'd0);
    check("clr rd_valid", 32'(rd_valid), 32'd0);
    wait_ready("clr walk", 64);
    cyc(1'b1, 1'b0, 6'd7, 32'h0, 2'b00);
    check("post-clr addr7 valid", 32'(rd_valid), 32'd1);
    check("post-clr addr7", d_out, 32'h0);
    cyc(1'b1, 1'b0, 6'd5, 32'h0, 2'b00);
    check("post-clr addr5", d_out, 32'h0);

    // Async reset partway through a walk, landing between clock edges.
    cyc(1'b1, 1'b1, 6'd9, 32'h13579BDF, 2'b11);
    cyc(1'b1, 1'b0, 6'd9, 32'h0, 2'b00);
    check("addr9 readback", d_out, 32'h13579BDF);
    clr = 1'b1;
    cyc(1'b0, 1'b0, 6'd0, 32'h0, 2'b00);
    clr = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst d_out", d_out, 32'h0);
    check("async rst busy", 32'(busy), 32'd1);
    check("async rst ready", 32'(ready), 32'd0);
    check("async rst rd_valid", 32'(rd_valid), 32'd0);
    #2;
    rst = 1'b0;
    en = 1'b1; r_w = 1'b0; addr = 6'd0;
    wait_ready("rst walk", 64);
    cyc(1'b1, 1'b0, 6'd9, 32'h0, 2'b00);
    check("post-rst addr9 valid", 32'(rd_valid), 32'd1);
    check("post-rst addr9", d_out, 32'h0);
    cyc(1'b0, 1'b0, 6'd0, 32'h0, 2'b00);
    check("idle after read valid", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_banked.md
Name: mem_banked

Overview:
- Parametrised single-port synchronous RAM built as a grid of banks.
- Width expansion: LANES = DATA_W/LANE_W lanes side by side, each with its own write enable.
- Depth expansion: NBANKS = 2^(ADDR_W-BANK_ADDR_W) banks stacked in depth, selected by the upper address bits.
- Next-generation word memory for the datapath. Adds a registered read with valid flag, per-lane writes and a self-clearing init sequencer after reset or on command.

Parameters:
- DATA_W, 32: total word width; must be a multiple of LANE_W.
- LANE_W, 16: width of one lane (one bank column).
- ADDR_W, 6: word address width; DEPTH = 2^ADDR_W = 64.
- BANK_ADDR_W, 5: per-bank address width (32 words/bank); must be <= ADDR_W.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous request to re-zero the whole array.
- en  input  1  access request, qualified by ready.
- r_w  input  1  1 = write, 0 = read.
- addr  input  ADDR_W  word address. Upper ADDR_W-BANK_ADDR_W bits = bank, lower BANK_ADDR_W bits = row.
- d_in  input  DATA_W  write data; lane k = d_in[k*LANE_W +: LANE_W].
- lane_we  input  LANES  per-lane write enable; used only when r_w=1.
- d_out  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse: d_out updated by a read.
- ready  output  1  accepts accesses (state RUN).
- busy  output  1  init sequencer active; always equal to !ready.

Behaviour:
- Reset (rst=1, asynchronous):
  - d_out=0, rd_valid=0, ready=0, busy=1.
  - init counter=0; state=INIT.
  - Array contents are not reset directly; the INIT walk clears them.
- State INIT:
  - Each cycle writes 0 to all lanes at address cnt, then cnt++.
  - When cnt==DEPTH-1 is written, next state is RUN.
  - INIT takes exactly DEPTH cycles after rst deasserts; ready rises on the edge following the last clear write.
  - en is ignored in INIT: no write, no read, rd_valid stays 0.
- State RUN:
  - Write (en=1, r_w=1): on the clk edge, lane k of word addr takes d_in lane k if lane_we[k]=1. Other lanes are unchanged. d_out is unchanged. rd_valid=0.
  - Write with lane_we=0 is a no-op.
  - Read (en=1, r_w=0): d_out <= word at addr on that edge, so data is visible one cycle after the request. rd_valid=1 for that one cycle.
  - Back-to-back reads give back-to-back rd_valid pulses.
  - Idle (en=0): d_out holds its last value; rd_valid=0.
  - Read of an address written in the previous cycle returns the new data.
- clr:
  - Sampled on a clk edge in any state: next state=INIT, cnt=0, ready=0, rd_valid=0.
  - An access presented in the same cycle as clr is dropped.
  - clr asserted during INIT restarts the walk from address 0.
  - clr has priority over en.
- Reset mid-operation: takes effect immediately. Outputs return to reset values; the init walk restarts from 0 after release.
- Bank decode:
  - bank = addr[ADDR_W-1:BANK_ADDR_W], row = addr[BANK_ADDR_W-1:0].
  - Exactly one bank row per lane is accessed.
  - With ADDR_W==BANK_ADDR_W there is a single bank.
  - The read mux selects the bank registered with the read request.
- All addresses are in range (DEPTH = 2^ADDR_W); no error path.

Test Plan:
- Pulse rst, release, hold en=1 r_w=0 addr=0 -> ready=0 for exactly 64 cycles, rd_valid never set. Then read addr 0..63 -> all d_out=0x00000000, rd_valid pulse each cycle.
- Write addr=5 d_in=0xDEADBEEF lane_we=2'b11, next cycle read addr=5 -> d_out=0xDEADBEEF one cycle after the read, rd_valid=1 for 1 cycle.
- Partial-lane write, after previous step: write addr=5 d_in=0x12345678 lane_we=2'b01, read addr=5 -> 0xDEAD5678. Then write lane_we=2'b10 d_in=0xAAAA0000 -> read gives 0xAAAA5678.
- Bank boundary:
  - Write addr=31 = 0x11111111 and addr=32 = 0x22222222 (different banks), read 32 then 31 back-to-back -> 0x22222222 then 0x11111111 on consecutive cycles.
  - Write addr=32 while checking addr=0 -> addr=0 is unchanged.
- clr in RUN, same cycle as a write of 0x5555AAAA to addr=7 -> write dropped, ready low 64 cycles. Afterwards addr=7 and addr=5 read 0x00000000.
- Async rst asserted mid-INIT (cycle 20), with no clk edge -> d_out=0, busy=1 immediately. After release, full 64-cycle walk before ready=1.
